// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, receiver state encoding,
// frame-format payload and the parity helper used by both directions.
package uart_pkg;

   localparam int unsigned DATA_BITS      = 8;
   localparam int unsigned LINE_IDLE_BITS = 10;

   typedef enum logic [2:0] {
      WAIT_LINE,
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   typedef struct packed {
      logic two_stop;
      logic parity_en;
      logic parity_even;
   } rx_cfg_t;

   // Expected parity bit for a data word: even parity makes the total count of ones even
   function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic even);
      return even ? (^data) : ~(^data);
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs with a
// configurable reset value (idle level of the source).
module uart_sync2 #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   logic meta;

   // Two-stage capture of the asynchronous input
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RESET_VALUE;
         dout <= RESET_VALUE;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional parity, 1 or 2 stop bits,
// one-deep output register with parity/framing/overrun flags.
// Optional feature macro: UART_RX_BREAK_DETECT_EN adds break_o and turns an
// all-zero frame into a break pulse followed by a line-idle resync.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_DIVIDER_WIDTH = 16
) (
   input  logic                           clock_i,
   input  logic                           reset_i,
   input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
   input  logic                           serial_i,
   output logic [DATA_BITS-1:0]           data_o,
   output logic                           valid_o,
   input  logic                           read_i,
   output logic                           parity_error_o,
   output logic                           framing_error_o,
   output logic                           overrun_error_o,
   output logic                           busy_o,
   input  logic                           two_stop_bits_i,
   input  logic                           parity_bit_i,
`ifdef UART_RX_BREAK_DETECT_EN
   output logic                           break_o,
`endif
   input  logic                           parity_even_i
);

   localparam int unsigned DW  = CLOCK_DIVIDER_WIDTH;
   localparam int unsigned BCW = 4;

   logic                 line, line_q;
   logic [DW-1:0]        d_live, h_live, reload;
   rx_state_e            state_q, state_d;
   logic [DW-1:0]        timer_q, timer_d;
   logic [BCW-1:0]       cnt_q, cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 stop_idx_q, stop_idx_d;
   logic [DW-1:0]        div_q, div_d;
   rx_cfg_t              cfg_q, cfg_d;
   logic                 complete;
   logic                 brk;
`ifdef UART_RX_BREAK_DETECT_EN
   logic                 brk_cand_q, brk_cand_d;
`endif

   logic [DATA_BITS-1:0] data_n;
   logic                 valid_n, perr_n, ferr_n, ovr_n, busy_n;

   uart_sync2 #(.RESET_VALUE(1'b1)) u_sync (
      .clk   (clock_i),
      .reset (reset_i),
      .din   (serial_i),
      .dout  (line)
   );

   assign d_live = (clock_divider_i == '0) ? DW'(1) : clock_divider_i;
   assign h_live = d_live >> 1;
   assign reload = div_q - DW'(1);

   // State register
   always_ff @(posedge clock_i) begin
      if (reset_i) state_q <= WAIT_LINE;
      else         state_q <= state_d;
   end

   // Next-state and frame datapath decode
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      stop_idx_d = stop_idx_q;
      div_d      = div_q;
      cfg_d      = cfg_q;
      complete   = 1'b0;
      brk        = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_cand_d = brk_cand_q;
`endif
      case (state_q)
         // timer counts up through one bit time, cnt counts high bit times
         WAIT_LINE: begin
            if (!line) begin
               timer_d = '0;
               cnt_d   = '0;
            end else if (timer_q >= d_live - DW'(1)) begin
               timer_d = '0;
               if (cnt_q == BCW'(LINE_IDLE_BITS - 1)) state_d = IDLE;
               else                                   cnt_d   = cnt_q + BCW'(1);
            end else begin
               timer_d = timer_q + DW'(1);
            end
         end
         IDLE: begin
            if (line_q && !line) begin
               div_d      = d_live;
               cfg_d      = '{two_stop: two_stop_bits_i, parity_en: parity_bit_i,
                              parity_even: parity_even_i};
               perr_d     = 1'b0;
               ferr_d     = 1'b0;
               stop_idx_d = 1'b0;
               cnt_d      = '0;
`ifdef UART_RX_BREAK_DETECT_EN
               brk_cand_d = 1'b1;
`endif
               // With a zero half-bit the edge sample itself is the start-bit sample
               if (h_live == '0) begin
                  state_d = DATA;
                  timer_d = d_live - DW'(1);
               end else begin
                  state_d = START;
                  timer_d = h_live - DW'(1);
               end
            end
         end
         START: begin
            if (timer_q != '0) begin
               timer_d = timer_q - DW'(1);
            end else if (!line) begin
               state_d = DATA;
               timer_d = reload;
            end else begin
               state_d = IDLE;
            end
         end
         DATA: begin
            if (timer_q != '0) begin
               timer_d = timer_q - DW'(1);
            end else begin
               shift_d = {line, shift_q[DATA_BITS-1:1]};
               timer_d = reload;
               if (cnt_q == BCW'(DATA_BITS - 1)) state_d = cfg_q.parity_en ? PARITY : STOP;
               else                              cnt_d   = cnt_q + BCW'(1);
            end
         end
         PARITY: begin
            if (timer_q != '0) begin
               timer_d = timer_q - DW'(1);
            end else begin
               perr_d  = (line != parity_of(shift_q, cfg_q.parity_even));
               timer_d = reload;
               state_d = STOP;
`ifdef UART_RX_BREAK_DETECT_EN
               brk_cand_d = brk_cand_q & ~line;
`endif
            end
         end
         STOP: begin
            if (timer_q != '0) begin
               timer_d = timer_q - DW'(1);
            end else begin
               ferr_d  = ferr_q | ~line;
               timer_d = reload;
`ifdef UART_RX_BREAK_DETECT_EN
               brk_cand_d = brk_cand_q & ~line;
`endif
               if (!cfg_q.two_stop || stop_idx_q) begin
                  state_d = IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                  if (shift_q == '0 && brk_cand_d) begin
                     brk     = 1'b1;
                     state_d = WAIT_LINE;
                     timer_d = '0;
                     cnt_d   = '0;
                  end else begin
                     complete = 1'b1;
                  end
`else
                  complete = 1'b1;
`endif
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = WAIT_LINE;
            timer_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Host-side output register: completion wins over a same-cycle read
   always_comb begin
      data_n  = data_o;
      valid_n = valid_o;
      perr_n  = parity_error_o;
      ferr_n  = framing_error_o;
      ovr_n   = overrun_error_o;
      busy_n  = (state_d != IDLE);
      if (complete) begin
         if (!valid_o || read_i) begin
            data_n  = shift_q;
            perr_n  = perr_q;
            ferr_n  = ferr_d;
            valid_n = 1'b1;
         end else begin
            ovr_n = 1'b1;
         end
      end else if (read_i && valid_o) begin
         valid_n = 1'b0;
         perr_n  = 1'b0;
         ferr_n  = 1'b0;
         ovr_n   = 1'b0;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         line_q          <= 1'b1;
         timer_q         <= '0;
         cnt_q           <= '0;
         shift_q         <= '0;
         perr_q          <= 1'b0;
         ferr_q          <= 1'b0;
         stop_idx_q      <= 1'b0;
         div_q           <= DW'(1);
         cfg_q           <= '0;
         data_o          <= '0;
         valid_o         <= 1'b0;
         parity_error_o  <= 1'b0;
         framing_error_o <= 1'b0;
         overrun_error_o <= 1'b0;
         busy_o          <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
         brk_cand_q      <= 1'b0;
         break_o         <= 1'b0;
`endif
      end else begin
         line_q          <= line;
         timer_q         <= timer_d;
         cnt_q           <= cnt_d;
         shift_q         <= shift_d;
         perr_q          <= perr_d;
         ferr_q          <= ferr_d;
         stop_idx_q      <= stop_idx_d;
         div_q           <= div_d;
         cfg_q           <= cfg_d;
         data_o          <= data_n;
         valid_o         <= valid_n;
         parity_error_o  <= perr_n;
         framing_error_o <= ferr_n;
         overrun_error_o <= ovr_n;
         busy_o          <= busy_n;
`ifdef UART_RX_BREAK_DETECT_EN
         brk_cand_q      <= brk_cand_d;
         break_o         <= brk;
`endif
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, hand-written
// corner sequences and randomized frames against a bit-level line model.
module tb_uart_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] div;
   logic        serial;
   logic [7:0]  data;
   logic        valid;
   logic        read;
   logic        perr, ferr, ovr, busy;
   logic        two_stop, par_en, par_even;
`ifdef UART_RX_BREAK_DETECT_EN
   logic        brk;
`endif

   int total = 0;
   int bad   = 0;
   int break_cnt = 0;

   always #5 clk = ~clk;

   uart_rx #(.CLOCK_DIVIDER_WIDTH(16)) dut (
      .clock_i         (clk),
      .reset_i         (reset),
      .clock_divider_i (div),
      .serial_i        (serial),
      .data_o          (data),
      .valid_o         (valid),
      .read_i          (read),
      .parity_error_o  (perr),
      .framing_error_o (ferr),
      .overrun_error_o (ovr),
      .busy_o          (busy),
      .two_stop_bits_i (two_stop),
      .parity_bit_i    (par_en),
`ifdef UART_RX_BREAK_DETECT_EN
      .break_o         (brk),
`endif
      .parity_even_i   (par_even)
   );

`ifdef UART_RX_BREAK_DETECT_EN
   always @(posedge clk) if (brk === 1'b1) break_cnt++;
`endif

   typedef struct {
      int       dv;
      bit       pe;
      bit       ev;
      bit       ts;
      bit [7:0] d;
      bit       pv;
      bit [1:0] sl;
      bit [7:0] exp_d;
      bit       exp_pe;
      bit       exp_fe;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance n clock edges, ending 1 time unit after the last edge
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic hold_bit(input logic b, input int d);
      serial = b;
      step(d);
   endtask

   task automatic send_frame(input logic [7:0] d8, input int dv, input bit pe, input bit ev,
                             input bit ts, input bit pv, input bit [1:0] sl);
      int dd;
      dd       = (dv == 0) ? 1 : dv;
      div      = 16'(dv);
      par_en   = pe;
      par_even = ev;
      two_stop = ts;
      hold_bit(1'b0, dd);
      for (int i = 0; i < 8; i++) hold_bit(d8[i], dd);
      if (pe) hold_bit(pv, dd);
      hold_bit(~sl[0], dd);
      if (ts) hold_bit(~sl[1], dd);
   endtask

   task automatic wait_valid(input string name, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (valid === 1'b1) break;
         step(1);
      end
      check(name, 32'(valid), 32'd1);
   endtask

   task automatic read_pulse();
      read = 1'b1;
      step(1);
      read = 1'b0;
   endtask

   initial begin
      vecs[0] = '{16, 0, 0, 0, 8'hA5, 0, 2'b00, 8'hA5, 0, 0};
      vecs[1] = '{ 8, 1, 1, 0, 8'h07, 0, 2'b00, 8'h07, 1, 0};
      vecs[2] = '{ 8, 1, 0, 0, 8'h07, 0, 2'b00, 8'h07, 0, 0};
      vecs[3] = '{16, 0, 0, 1, 8'h3C, 0, 2'b10, 8'h3C, 0, 1};
      vecs[4] = '{ 1, 0, 0, 0, 8'h5A, 0, 2'b00, 8'h5A, 0, 0};
      vecs[5] = '{ 0, 0, 0, 0, 8'h5A, 0, 2'b00, 8'h5A, 0, 0};
      vecs[6] = '{ 3, 1, 1, 1, 8'hFF, 0, 2'b00, 8'hFF, 0, 0};
      vecs[7] = '{ 5, 1, 0, 0, 8'h80, 1, 2'b01, 8'h80, 1, 1};

      reset = 1'b1; serial = 1'b1; read = 1'b0; div = 16'd16;
      two_stop = 1'b0; par_en = 1'b0; par_even = 1'b0;
      step(3);
      check("reset_valid", 32'(valid), 0);
      check("reset_data", 32'(data), 0);
      check("reset_busy", 32'(busy), 1);
      check("reset_errs", 32'({perr, ferr, ovr}), 0);
      reset = 1'b0;
      step(5);
      check("line_check_busy", 32'(busy), 1);
      step(10 * 16 + 5);
      check("idle_after_line_check", 32'(busy), 0);

      // Directed frame table
      foreach (vecs[i]) begin
         int dd;
         dd = (vecs[i].dv == 0) ? 1 : vecs[i].dv;
         send_frame(vecs[i].d, vecs[i].dv, vecs[i].pe, vecs[i].ev, vecs[i].ts, vecs[i].pv, vecs[i].sl);
         serial = 1'b1;
         wait_valid($sformatf("vec%0d_valid", i), 30 * dd + 20);
         check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_d));
         check($sformatf("vec%0d_perr", i), 32'(perr), 32'(vecs[i].exp_pe));
         check($sformatf("vec%0d_ferr", i), 32'(ferr), 32'(vecs[i].exp_fe));
         read_pulse();
         check($sformatf("vec%0d_read_clears", i), 32'({valid, perr, ferr}), 0);
         step(2 * dd + 2);
      end

      // Overrun: two back-to-back frames with no read
      send_frame(8'h11, 8, 0, 0, 0, 0, 2'b00);
      send_frame(8'h22, 8, 0, 0, 0, 0, 2'b00);
      serial = 1'b1;
      step(24);
      check("ovr_valid", 32'(valid), 1);
      check("ovr_data_kept", 32'(data), 32'h11);
      check("ovr_flag", 32'(ovr), 1);
      read_pulse();
      check("ovr_read_clears", 32'({valid, ovr}), 0);
      step(16);

      // Read on the completion cycle of the second frame: H=4, final sample 9 bit times in
      send_frame(8'h11, 8, 0, 0, 0, 0, 2'b00);
      fork
         send_frame(8'h22, 8, 0, 0, 0, 0, 2'b00);
         begin
            step(2 + 4 + 8 * 9);
            read = 1'b1;
            step(1);
            read = 1'b0;
            check("rdcomp_valid_held", 32'(valid), 1);
            check("rdcomp_data", 32'(data), 32'h22);
         end
      join
      serial = 1'b1;
      step(2);
      check("rdcomp_no_ovr", 32'(ovr), 0);
      read_pulse();
      step(16);

      // Short glitch below half a bit is a false start
      div = 16'd16;
      serial = 1'b0;
      step(3);
      serial = 1'b1;
      step(16 * 12);
      check("glitch_no_valid", 32'(valid), 0);
      check("glitch_idle", 32'(busy), 0);

      // Reset mid-frame with the line held low
      serial = 1'b0;
      step(16 * 3);
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(40);
      check("rst_low_busy", 32'(busy), 1);
      serial = 1'b1;
      step(16 * 5);
      check("rst_half_wait_busy", 32'(busy), 1);
      check("rst_half_wait_valid", 32'(valid), 0);
      step(16 * 5 + 8);
      check("rst_wait_done", 32'(busy), 0);
      check("rst_no_valid", 32'(valid), 0);

      // All-zero frame with a low stop bit
      begin
         int bc;
         bc = break_cnt;
         send_frame(8'h00, 4, 0, 0, 0, 0, 2'b01);
         serial = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
         step(20);
         check("break_pulses", 32'(break_cnt - bc), 1);
         check("break_no_valid", 32'(valid), 0);
         check("break_resync_busy", 32'(busy), 1);
         step(10 * 4 + 10);
         check("break_resynced", 32'(busy), 0);
`else
         wait_valid("zero_frame_valid", 200);
         check("zero_frame_data", 32'(data), 0);
         check("zero_frame_ferr", 32'(ferr), 1);
         check("zero_frame_no_break", 32'(break_cnt - bc), 0);
         read_pulse();
`endif
         step(8);
      end

      // Randomized frames against the line-level model
      for (int n = 0; n < 30; n++) begin
         int       dv, dd, bc;
         bit [7:0] d8;
         bit       pe, ev, ts, pv, exp_pe, exp_fe, is_break;
         bit [1:0] sl;
         dv = $urandom_range(0, 6);
         dd = (dv == 0) ? 1 : dv;
         pe = 1'($urandom_range(0, 1));
         ev = 1'($urandom_range(0, 1));
         ts = 1'($urandom_range(0, 1));
         d8 = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         sl = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         // Correct parity: total ones across data plus parity bit even (even mode) or odd
         pv = ev ? (^d8) : ~(^d8);
         if ($urandom_range(0, 3) == 0) pv = ~pv;
         exp_pe   = pe && ((($countones(d8) + int'(pv)) % 2) != (ev ? 0 : 1));
         exp_fe   = sl[0] | (ts & sl[1]);
         is_break = (d8 == 8'h00) && sl[0] && (!ts || sl[1]) && (!pe || !pv);
         bc = break_cnt;
         send_frame(d8, dv, pe, ev, ts, pv, sl);
         serial = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
         if (is_break) begin
            step(4);
            check($sformatf("rnd%0d_break", n), 32'(break_cnt - bc), 1);
            check($sformatf("rnd%0d_break_no_valid", n), 32'(valid), 0);
            step(11 * dd + 4);
            continue;
         end
`endif
         wait_valid($sformatf("rnd%0d_valid", n), 30 * dd + 20);
         check($sformatf("rnd%0d_data", n), 32'(data), 32'(d8));
         check($sformatf("rnd%0d_perr", n), 32'(perr), 32'(exp_pe));
         check($sformatf("rnd%0d_ferr", n), 32'(ferr), 32'(exp_fe));
         check($sformatf("rnd%0d_no_break", n), 32'(break_cnt - bc), 0);
         read_pulse();
         check($sformatf("rnd%0d_read", n), 32'(valid), 0);
         step(2 * dd + 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #5000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
